mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter sharing the single backing-memory block port between the instruction-side and data-side cache controllers. It grants one whole-block transaction (read fill or dirty write-back, 512 bits) at a time using round-robin priority. It registers the request onto the memory port, returns the block and a ready pulse to the owner, and aborts with an error if memory does not answer within a bounded number of cycles. It sits between the cache controllers' `mem_req_*` ports and the memory model/controller.

## Interface
- `WORD_SIZE`, default 32: address width.
- `BLOCK_DATA_WIDTH`, default 512: block data width.
- `TIMEOUT_CYCLES`, default 255: maximum wait for `mem_req_ready`, counted from the first cycle `mem_req_enable` is high. Legal range is 1..255; the counter is 8 bits.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_enable` in 1 / `req1_enable` in 1: transaction request, level-held until the matching ready.
- `req0_rw` in 1 / `req1_rw` in 1: 0 is a block read, 1 is a block write.
- `req0_addr` in WORD_SIZE / `req1_addr` in WORD_SIZE: block address.
- `req0_dataout` in BLOCK_DATA_WIDTH / `req1_dataout` in BLOCK_DATA_WIDTH: write-back block.
- `req0_datain` out BLOCK_DATA_WIDTH / `req1_datain` out BLOCK_DATA_WIDTH: returned read block, registered.
- `req0_ready` out 1 / `req1_ready` out 1: one-cycle completion pulse.
- `req0_error` out 1 / `req1_error` out 1: qualifies ready; set when the transaction timed out.
- `mem_req_enable` out 1, `mem_req_rw` out 1, `mem_req_addr` out WORD_SIZE, `mem_req_dataout` out BLOCK_DATA_WIDTH: registered memory request.
- `mem_req_datain` in BLOCK_DATA_WIDTH, `mem_req_ready` in 1: memory response. `mem_req_datain` is valid when `mem_req_ready` is high.
- `grant_owner` out 1: current or last owner, for debug.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **FSM states:** IDLE, MEM, RESP.
- **IDLE:**
  - With no enable asserted, stay in IDLE.
  - With exactly one enable asserted, grant that requester.
  - With both asserted, grant the requester that is not `last_grant`.
  - On grant: latch rw, addr and dataout from the winner into the `mem_req_*` registers, set `mem_req_enable`, set `owner`, clear the timeout counter, and go to MEM.
- **MEM:**
  - Hold `mem_req_*` constant and increment the counter each cycle.
  - If `mem_req_ready` is seen: capture `mem_req_datain` into `reqN_datain` of the owner (reads only; writes leave datain unchanged), clear `mem_req_enable`, set `error_q=0`, go to RESP.
  - If instead the counter reaches `TIMEOUT_CYCLES-1` without ready: clear `mem_req_enable`, set `error_q=1`, go to RESP.
- **RESP:**
  - Pulse `reqN_ready` (and `reqN_error=error_q`) of the owner for exactly one cycle.
  - Set `last_grant=owner` and go to IDLE.
- **Requester rule:** deassert enable on the edge where ready is sampled high. A new request from the same requester may be raised in the first IDLE cycle and is arbitrated normally.
- Enables raised while `busy` wait; they are not lost, because they are level-held.
- `mem_req_ready` arriving in IDLE or RESP is ignored.
- `mem_req_ready` in the same cycle as the timeout compare: ready wins and there is no error.
- Non-owner requester outputs stay unchanged throughout a transaction.

## Timing
- **Reset (asynchronous):**
  - State IDLE.
  - `mem_req_enable=0`, `mem_req_rw=0`, `mem_req_addr=0`, `mem_req_dataout=0`.
  - `req*_ready=0`, `req*_error=0`, `req*_datain=0`.
  - `grant_owner=0`, `busy=0`, counter 0.
  - `last_grant=1`, so requester 0 wins the first tie.
- **Reset mid-transaction:** abandons the transaction immediately. No ready pulse is produced.
- **Latency:**
  - Request sampled at edge T: `mem_req_enable` is high from T+1.
  - Memory ready sampled at edge M: `reqN_ready` and datain are valid from M+1 for one cycle.
  - Minimum round trip is 3 cycles, with ready asserted in the first MEM cycle.
- **Timeout:** error ready is visible `TIMEOUT_CYCLES`+1 cycles after `mem_req_enable` rose.
- **Back-to-back:** there is at least one IDLE cycle between transactions. Under continuous contention, grants alternate 0,1,0,1.

## Structure
- Shared `cache_pkg` holds:
  - `WORD_SIZE` and `BLOCK_DATA_WIDTH` defaults.
  - The `arb_state_t` enum (IDLE, MEM, RESP).
  - The `MEM_RW_READ`/`MEM_RW_WRITE` constants, also used by `cache_controller`.
- Optional sub-module: `rr_pick2`, a combinational 2-way round-robin pick taking `req[1:0]` and `last` and producing `gnt` and `valid`. The FSM, counter and datapath registers stay in the top module.

## Test plan
- **Single read:** reset, then `req0` read of addr `0x0000_1A40`; memory returns ready after 4 cycles with a block whose word i is `0xDEADBEEF+i`. Required: `mem_req_addr=0x0000_1A40`, `mem_req_rw=0`, `req0_ready` for one cycle, `req0_datain` word 15 = `0xDEADBEFE`, `req0_error=0`.
- **Simultaneous requests after reset:** `req0` read and `req1` write raised in the same cycle. Required: `req0` is served first; then `req1` with `mem_req_rw=1` and `mem_req_dataout` equal to `req1_dataout`; `req1_datain` is unchanged.
- **Continuous contention:** both requesters re-request immediately for 6 transactions. Required: grant order 0,1,0,1,0,1.
- **Timeout:** `TIMEOUT_CYCLES=8` and memory never readies. Required: `req1_ready=1` and `req1_error=1` on the 9th cycle after `mem_req_enable` rose; `mem_req_enable` is 0 by then; the next request proceeds normally.
- **Ready on the timeout compare cycle:** `mem_req_ready` asserted in the same cycle as the timeout compare. Required: `error=0` and data captured.
- **Reset mid-transaction:** `rst_n` pulled low during MEM. Required: all outputs go to reset values asynchronously, no ready pulse, and the next tie is won by `req0`.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache-subsystem definitions: default widths, memory op encoding and
// the arbiter state type used by the memory port arbiter.
package cache_pkg;

  localparam int DEFAULT_WORD_SIZE        = 32;
  localparam int DEFAULT_BLOCK_DATA_WIDTH = 512;

  localparam logic MEM_RW_READ  = 1'b0;
  localparam logic MEM_RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Round-robin helper: the side that did not win last time.
  function automatic logic other_side(input logic side);
    return ~side;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of both requester ports and the shared memory port seen by the arbiter.
// The arbiter uses the slave view; requesters and memory drive the master view.
interface mem_port_arbiter_if
  import cache_pkg::*;
#(
  parameter int WORD_SIZE        = DEFAULT_WORD_SIZE,
  parameter int BLOCK_DATA_WIDTH = DEFAULT_BLOCK_DATA_WIDTH
);

  logic                        req0_enable;
  logic                        req0_rw;
  logic [WORD_SIZE-1:0]        req0_addr;
  logic [BLOCK_DATA_WIDTH-1:0] req0_dataout;
  logic [BLOCK_DATA_WIDTH-1:0] req0_datain;
  logic                        req0_ready;
  logic                        req0_error;

  logic                        req1_enable;
  logic                        req1_rw;
  logic [WORD_SIZE-1:0]        req1_addr;
  logic [BLOCK_DATA_WIDTH-1:0] req1_dataout;
  logic [BLOCK_DATA_WIDTH-1:0] req1_datain;
  logic                        req1_ready;
  logic                        req1_error;

  logic                        mem_req_enable;
  logic                        mem_req_rw;
  logic [WORD_SIZE-1:0]        mem_req_addr;
  logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout;
  logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain;
  logic                        mem_req_ready;

  modport slave (
    input  req0_enable, req0_rw, req0_addr, req0_dataout,
    input  req1_enable, req1_rw, req1_addr, req1_dataout,
    input  mem_req_datain, mem_req_ready,
    output req0_datain, req0_ready, req0_error,
    output req1_datain, req1_ready, req1_error,
    output mem_req_enable, mem_req_rw, mem_req_addr, mem_req_dataout
  );

  modport master (
    output req0_enable, req0_rw, req0_addr, req0_dataout,
    output req1_enable, req1_rw, req1_addr, req1_dataout,
    output mem_req_datain, mem_req_ready,
    input  req0_datain, req0_ready, req0_error,
    input  req1_datain, req1_ready, req1_error,
    input  mem_req_enable, mem_req_rw, mem_req_addr, mem_req_dataout
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: a lone request wins outright, a tie
// goes to the side that was not granted last.
module rr_pick2
  import cache_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);

  // Winner selection from the current request pair and the previous grant.
  always_comb begin
    gnt   = 1'b0;
    valid = |req;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = other_side(last);
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one block-wide memory port between the
// instruction-side and data-side cache controllers, with a bounded wait.
module mem_port_arbiter
  import cache_pkg::*;
#(
  parameter int WORD_SIZE        = DEFAULT_WORD_SIZE,
  parameter int BLOCK_DATA_WIDTH = DEFAULT_BLOCK_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES   = 255
)(
  input  logic                  clk,
  input  logic                  rst_n,
  mem_port_arbiter_if.slave     bus,
  output logic                  grant_owner,
  output logic                  busy
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_t                  state_r,    state_next_s;
  logic [7:0]                  cnt_r,      cnt_next_s;
  logic                        owner_r,    owner_next_s;
  logic                        last_r,     last_next_s;
  logic                        busy_r,     busy_next_s;
  logic                        mem_en_r,   mem_en_next_s;
  logic                        mem_rw_r,   mem_rw_next_s;
  logic [WORD_SIZE-1:0]        mem_addr_r, mem_addr_next_s;
  logic [BLOCK_DATA_WIDTH-1:0] mem_dout_r, mem_dout_next_s;
  logic [BLOCK_DATA_WIDTH-1:0] din0_r,     din0_next_s;
  logic [BLOCK_DATA_WIDTH-1:0] din1_r,     din1_next_s;
  logic                        rdy0_r,     rdy0_next_s;
  logic                        rdy1_r,     rdy1_next_s;
  logic                        err0_r,     err0_next_s;
  logic                        err1_r,     err1_next_s;
  logic                        pick_gnt_s;
  logic                        pick_valid_s;

  rr_pick2 u_pick (
    .req   ({bus.req1_enable, bus.req0_enable}),
    .last  (last_r),
    .gnt   (pick_gnt_s),
    .valid (pick_valid_s)
  );

  // Next-state and next-register values; ready/error default low so they pulse.
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = cnt_r;
    owner_next_s    = owner_r;
    last_next_s     = last_r;
    mem_en_next_s   = mem_en_r;
    mem_rw_next_s   = mem_rw_r;
    mem_addr_next_s = mem_addr_r;
    mem_dout_next_s = mem_dout_r;
    din0_next_s     = din0_r;
    din1_next_s     = din1_r;
    rdy0_next_s     = 1'b0;
    rdy1_next_s     = 1'b0;
    err0_next_s     = 1'b0;
    err1_next_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_next_s    = MEM;
          owner_next_s    = pick_gnt_s;
          cnt_next_s      = 8'd0;
          mem_en_next_s   = 1'b1;
          mem_rw_next_s   = pick_gnt_s ? bus.req1_rw      : bus.req0_rw;
          mem_addr_next_s = pick_gnt_s ? bus.req1_addr    : bus.req0_addr;
          mem_dout_next_s = pick_gnt_s ? bus.req1_dataout : bus.req0_dataout;
        end else begin
          state_next_s = IDLE;
        end
      end
      MEM: begin
        // A ready on the final compare cycle still counts as a clean response.
        if (bus.mem_req_ready) begin
          state_next_s  = RESP;
          mem_en_next_s = 1'b0;
          if (owner_r) begin
            rdy1_next_s = 1'b1;
          end else begin
            rdy0_next_s = 1'b1;
          end
          if (mem_rw_r == MEM_RW_WRITE) begin
            din0_next_s = din0_r;
          end else if (owner_r) begin
            din1_next_s = bus.mem_req_datain;
          end else begin
            din0_next_s = bus.mem_req_datain;
          end
        end else if (cnt_r == TO_LAST) begin
          state_next_s  = RESP;
          mem_en_next_s = 1'b0;
          if (owner_r) begin
            rdy1_next_s = 1'b1;
            err1_next_s = 1'b1;
          end else begin
            rdy0_next_s = 1'b1;
            err0_next_s = 1'b1;
          end
        end else begin
          cnt_next_s = cnt_r + 8'd1;
        end
      end
      RESP: begin
        last_next_s  = owner_r;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s  = IDLE;
        mem_en_next_s = 1'b0;
      end
    endcase
    busy_next_s = (state_next_s != IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath, handshake and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= 8'd0;
      owner_r    <= 1'b0;
      last_r     <= 1'b1;
      busy_r     <= 1'b0;
      mem_en_r   <= 1'b0;
      mem_rw_r   <= MEM_RW_READ;
      mem_addr_r <= '0;
      mem_dout_r <= '0;
      din0_r     <= '0;
      din1_r     <= '0;
      rdy0_r     <= 1'b0;
      rdy1_r     <= 1'b0;
      err0_r     <= 1'b0;
      err1_r     <= 1'b0;
    end else begin
      cnt_r      <= cnt_next_s;
      owner_r    <= owner_next_s;
      last_r     <= last_next_s;
      busy_r     <= busy_next_s;
      mem_en_r   <= mem_en_next_s;
      mem_rw_r   <= mem_rw_next_s;
      mem_addr_r <= mem_addr_next_s;
      mem_dout_r <= mem_dout_next_s;
      din0_r     <= din0_next_s;
      din1_r     <= din1_next_s;
      rdy0_r     <= rdy0_next_s;
      rdy1_r     <= rdy1_next_s;
      err0_r     <= err0_next_s;
      err1_r     <= err1_next_s;
    end
  end

  assign bus.mem_req_enable  = mem_en_r;
  assign bus.mem_req_rw      = mem_rw_r;
  assign bus.mem_req_addr    = mem_addr_r;
  assign bus.mem_req_dataout = mem_dout_r;
  assign bus.req0_datain     = din0_r;
  assign bus.req1_datain     = din1_r;
  assign bus.req0_ready      = rdy0_r;
  assign bus.req1_ready      = rdy1_r;
  assign bus.req0_error      = err0_r;
  assign bus.req1_error      = err1_r;
  assign grant_owner         = owner_r;
  assign busy                = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a transaction-level
// model of round-robin ownership, response timing and returned data.
module tb_mem_port_arbiter;
  import cache_pkg::*;

  localparam int WS = 32;
  localparam int BW = 512;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic grant_owner;
  logic busy;
  int   checks   = 0;
  int   failures = 0;

  mem_port_arbiter_if #(.WORD_SIZE(WS), .BLOCK_DATA_WIDTH(BW)) bus ();

  mem_port_arbiter #(.WORD_SIZE(WS), .BLOCK_DATA_WIDTH(BW), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant_owner (grant_owner),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference model state: per-requester request, expected returned block,
  // outstanding flags and the last served requester.
  logic          req_rw_m   [2];
  logic [WS-1:0] req_addr_m [2];
  logic [BW-1:0] req_dout_m [2];
  logic [BW-1:0] exp_din    [2];
  bit            pending    [2];
  int            last_served;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] r;
    for (int i = 0; i < BW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic int model_winner();
    if (pending[0] && pending[1]) return 1 - last_served;
    else if (pending[0])          return 0;
    else                          return 1;
  endfunction

  function automatic logic obs_ready(input int who);
    return (who == 1) ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic obs_error(input int who);
    return (who == 1) ? bus.req1_error : bus.req0_error;
  endfunction

  function automatic logic [BW-1:0] obs_din(input int who);
    return (who == 1) ? bus.req1_datain : bus.req0_datain;
  endfunction

  task automatic raise(input int who, input logic rw, input logic [WS-1:0] a, input logic [BW-1:0] d);
    req_rw_m[who] = rw; req_addr_m[who] = a; req_dout_m[who] = d; pending[who] = 1'b1;
    if (who == 1) begin
      bus.req1_enable = 1'b1; bus.req1_rw = rw; bus.req1_addr = a; bus.req1_dataout = d;
    end else begin
      bus.req0_enable = 1'b1; bus.req0_rw = rw; bus.req0_addr = a; bus.req0_dataout = d;
    end
  endtask

  task automatic drop(input int who);
    pending[who] = 1'b0;
    if (who == 1) bus.req1_enable = 1'b0;
    else          bus.req0_enable = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_mem_en",   bus.mem_req_enable,  0);
    check("rst_mem_rw",   bus.mem_req_rw,      0);
    check("rst_mem_addr", bus.mem_req_addr,    0);
    check("rst_mem_dout", bus.mem_req_dataout, 0);
    check("rst_rdy0",     bus.req0_ready,      0);
    check("rst_rdy1",     bus.req1_ready,      0);
    check("rst_err0",     bus.req0_error,      0);
    check("rst_err1",     bus.req1_error,      0);
    check("rst_din0",     bus.req0_datain,     0);
    check("rst_din1",     bus.req1_datain,     0);
    check("rst_owner",    grant_owner,         0);
    check("rst_busy",     busy,                0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drop(0); drop(1);
    bus.mem_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    last_served = 1;
    exp_din[0] = '0; exp_din[1] = '0;
  endtask

  // One whole transaction: wait for grant, answer in MEM cycle rdy_cycle
  // (0 = never), check the response pulse, then release the request.
  task automatic serve(input int exp_owner, input int rdy_cycle, input logic [BW-1:0] mdata);
    int waited = 0;
    int other  = 1 - exp_owner;
    bit timed_out = (rdy_cycle == 0);
    bus.mem_req_ready = 1'b0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.mem_req_enable !== 1'b1 && waited < 20);
    if (bus.mem_req_enable !== 1'b1) begin
      check("grant_wait", bus.mem_req_enable, 1);
      return;
    end
    check("grant_owner", grant_owner,         exp_owner);
    check("mem_rw",      bus.mem_req_rw,      req_rw_m[exp_owner]);
    check("mem_addr",    bus.mem_req_addr,    req_addr_m[exp_owner]);
    check("mem_dout",    bus.mem_req_dataout, req_dout_m[exp_owner]);
    check("busy_mem",    busy,                1);
    for (int k = 1; k <= TO; k++) begin
      if (k == rdy_cycle) begin
        bus.mem_req_ready  = 1'b1;
        bus.mem_req_datain = mdata;
        break;
      end
      bus.mem_req_datain = rand_block();
      check("mem_en_hold",   bus.mem_req_enable, 1);
      check("mem_addr_hold", bus.mem_req_addr,   req_addr_m[exp_owner]);
      check("no_early_rdy",  obs_ready(exp_owner), 0);
      @(negedge clk);
    end
    if (!timed_out) @(negedge clk);
    bus.mem_req_ready = 1'b0;
    if (!timed_out && req_rw_m[exp_owner] == MEM_RW_READ) exp_din[exp_owner] = mdata;
    check("resp_ready",     obs_ready(exp_owner), 1);
    check("resp_error",     obs_error(exp_owner), timed_out);
    check("resp_din",       obs_din(exp_owner),   exp_din[exp_owner]);
    check("other_ready",    obs_ready(other),     0);
    check("other_din",      obs_din(other),       exp_din[other]);
    check("resp_mem_en",    bus.mem_req_enable,   0);
    @(posedge clk);
    #1;
    drop(exp_owner);
    last_served = exp_owner;
    @(negedge clk);
    check("idle_rdy0", bus.req0_ready, 0);
    check("idle_rdy1", bus.req1_ready, 0);
    check("idle_busy", busy,           0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] blk;
    int            w;
    rst_n = 1'b0;
    bus.req0_enable = 1'b0; bus.req0_rw = 1'b0; bus.req0_addr = '0; bus.req0_dataout = '0;
    bus.req1_enable = 1'b0; bus.req1_rw = 1'b0; bus.req1_addr = '0; bus.req1_dataout = '0;
    bus.mem_req_ready = 1'b0; bus.mem_req_datain = '0;
    pending[0] = 1'b0; pending[1] = 1'b0;
    apply_reset();

    // Memory ready while idle must be ignored.
    bus.mem_req_ready = 1'b1; bus.mem_req_datain = rand_block();
    repeat (2) @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check("idle_ign_busy", busy,               0);
    check("idle_ign_rdy0", bus.req0_ready,     0);
    check("idle_ign_din0", bus.req0_datain,    0);
    check("idle_ign_men",  bus.mem_req_enable, 0);

    // Single read with a known block.
    for (int i = 0; i < BW / 32; i++) blk[32*i +: 32] = 32'hDEADBEEF + 32'(i);
    raise(0, MEM_RW_READ, 32'h0000_1A40, rand_block());
    serve(model_winner(), 4, blk);
    check("word15", bus.req0_datain[511:480], 32'hDEADBEFE);

    // Simultaneous requests straight after reset.
    apply_reset();
    raise(0, MEM_RW_READ,  $urandom, rand_block());
    raise(1, MEM_RW_WRITE, $urandom, rand_block());
    serve(model_winner(), $urandom_range(1, TO - 1), rand_block());
    serve(model_winner(), $urandom_range(1, TO - 1), rand_block());
    check("write_keeps_din1", bus.req1_datain, 0);

    // Continuous contention: both re-request in the first idle cycle.
    raise(0, logic'($urandom_range(0, 1)), $urandom, rand_block());
    raise(1, logic'($urandom_range(0, 1)), $urandom, rand_block());
    for (int i = 0; i < 6; i++) begin
      w = model_winner();
      serve(w, $urandom_range(1, TO - 1), rand_block());
      if (i < 4) raise(w, logic'($urandom_range(0, 1)), $urandom, rand_block());
    end

    // Timeout, then a normal request from the same requester.
    raise(1, MEM_RW_READ, $urandom, rand_block());
    serve(model_winner(), 0, rand_block());
    raise(1, MEM_RW_READ, $urandom, rand_block());
    serve(model_winner(), 3, rand_block());

    // Ready on the timeout compare cycle, then minimum latency.
    raise(0, MEM_RW_READ, $urandom, rand_block());
    serve(model_winner(), TO, rand_block());
    raise(0, MEM_RW_READ, $urandom, rand_block());
    serve(model_winner(), 1, rand_block());

    // Reset during MEM abandons the transaction and restores the tie order.
    raise(1, MEM_RW_READ, $urandom, rand_block());
    repeat (3) @(negedge clk);
    check("pre_rst_men", bus.mem_req_enable, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    drop(0); drop(1);
    last_served = 1;
    exp_din[0] = '0; exp_din[1] = '0;
    @(negedge clk);
    check("rst_hold_rdy1", bus.req1_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdy1", bus.req1_ready, 0);
    check("post_rst_busy", busy,           0);
    raise(0, MEM_RW_READ,  $urandom, rand_block());
    raise(1, MEM_RW_WRITE, $urandom, rand_block());
    serve(model_winner(), $urandom_range(1, TO - 1), rand_block());
    serve(model_winner(), $urandom_range(1, TO - 1), rand_block());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
